// File: rtl/memory_helper_solver.sv
`default_nettype none
// ============================================================================
// Module      : memory_helper_solver
// Description : RISC-V load/store lane helper: size code, byte strobes, store
//               alignment, load extraction/extension, and an optional sticky
//               misalignment trap enabled by macro MEM_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_helper_solver (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addr_req,
    input  logic [2:0]  mem_mode,
    input  logic [63:0] st_data_in,
    input  logic        acc_valid,
    input  logic [63:0] ld_bus_data,
    output logic [63:0] addr,
    output logic [2:0]  msize,
    output logic [7:0]  strobe,
    output logic [63:0] st_data,
    output logic [63:0] ld_data,
    output logic        misaligned,
    output logic        err_sticky,
    output logic [63:0] err_addr
);

    localparam logic [2:0] c_mode_b   = 3'b000;
    localparam logic [2:0] c_mode_h   = 3'b001;
    localparam logic [2:0] c_mode_w   = 3'b010;
    localparam logic [2:0] c_mode_d   = 3'b011;
    localparam logic [2:0] c_mode_bu  = 3'b100;
    localparam logic [2:0] c_mode_hu  = 3'b101;
    localparam logic [2:0] c_mode_wu  = 3'b110;

    logic [2:0]  w_off;
    logic [5:0]  w_bit_off;
    logic [2:0]  w_msize;
    logic [7:0]  w_base_mask;
    logic [7:0]  w_strobe_raw;
    logic [63:0] w_ld_shift;
    logic [63:0] w_ld_data;
    logic        w_misaligned;

    assign w_off     = addr_req[2:0];
    assign w_bit_off = {w_off, 3'b000};

    always_comb begin
        w_msize     = 3'd0;
        w_base_mask = 8'h00;
        case (mem_mode)
            c_mode_b, c_mode_bu: begin w_msize = 3'd0; w_base_mask = 8'h01; end
            c_mode_h, c_mode_hu: begin w_msize = 3'd1; w_base_mask = 8'h03; end
            c_mode_w, c_mode_wu: begin w_msize = 3'd2; w_base_mask = 8'h0F; end
            c_mode_d:            begin w_msize = 3'd3; w_base_mask = 8'hFF; end
            default:             begin w_msize = 3'd0; w_base_mask = 8'h00; end
        endcase
    end

    // 8-bit shift drops any lane that would land past lane 7
    assign w_strobe_raw = w_base_mask << w_off;
    assign w_ld_shift   = ld_bus_data >> w_bit_off;

    always_comb begin
        w_ld_data = 64'd0;
        case (mem_mode)
            c_mode_b:  w_ld_data = {{56{w_ld_shift[7]}},  w_ld_shift[7:0]};
            c_mode_h:  w_ld_data = {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
            c_mode_w:  w_ld_data = {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
            c_mode_d:  w_ld_data = w_ld_shift;
            c_mode_bu: w_ld_data = {56'd0, w_ld_shift[7:0]};
            c_mode_hu: w_ld_data = {48'd0, w_ld_shift[15:0]};
            c_mode_wu: w_ld_data = {32'd0, w_ld_shift[31:0]};
            default:   w_ld_data = 64'd0;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic        r_err_sticky_q;
    logic        w_err_sticky_d;
    logic [63:0] r_err_addr_q;
    logic [63:0] w_err_addr_d;
    logic        w_err_hit;

    always_comb begin
        w_misaligned = 1'b0;
        case (mem_mode)
            c_mode_h, c_mode_hu: w_misaligned = addr_req[0];
            c_mode_w, c_mode_wu: w_misaligned = |addr_req[1:0];
            c_mode_d:            w_misaligned = |addr_req[2:0];
            default:             w_misaligned = 1'b0;
        endcase
    end

    assign w_err_hit = acc_valid & w_misaligned;

    // Only the first faulting address is kept until the next reset
    always_comb begin
        w_err_sticky_d = r_err_sticky_q | w_err_hit;
        w_err_addr_d   = r_err_addr_q;
        if (w_err_hit && !r_err_sticky_q) begin
            w_err_addr_d = addr_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky_q <= 1'b0;
            r_err_addr_q   <= 64'd0;
        end else begin
            r_err_sticky_q <= w_err_sticky_d;
            r_err_addr_q   <= w_err_addr_d;
        end
    end

    assign strobe     = w_misaligned ? 8'h00 : w_strobe_raw;
    assign err_sticky = r_err_sticky_q;
    assign err_addr   = r_err_addr_q;
`else
    logic w_unused;

    assign w_unused     = &{1'b0, clk, rst, acc_valid};
    assign w_misaligned = 1'b0;
    assign strobe       = w_strobe_raw;
    assign err_sticky   = 1'b0;
    assign err_addr     = 64'd0;
`endif

    assign addr       = addr_req;
    assign msize      = w_msize;
    assign st_data    = st_data_in << w_bit_off;
    assign ld_data    = w_ld_data;
    assign misaligned = w_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_memory_helper_solver.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_helper_solver
// Description : Self-checking bench for memory_helper_solver (vector table
//               through a scoreboard queue plus error-capture sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_helper_solver;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit c_chk = 1'b1;
`else
    localparam bit c_chk = 1'b0;
`endif

    typedef struct {
        logic [63:0] a;
        logic [2:0]  mode;
        logic [63:0] st_in;
        logic [63:0] bus;
        logic [2:0]  msize;
        logic [7:0]  strobe;
        logic [63:0] st_data;
        logic [63:0] ld;
        logic        mis;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [63:0] addr_req;
    logic [2:0]  mem_mode;
    logic [63:0] st_data_in;
    logic        acc_valid;
    logic [63:0] ld_bus_data;
    logic [63:0] addr;
    logic [2:0]  msize;
    logic [7:0]  strobe;
    logic [63:0] st_data;
    logic [63:0] ld_data;
    logic        misaligned;
    logic        err_sticky;
    logic [63:0] err_addr;

    int   checks;
    int   errors;
    vec_t tbl [15];
    vec_t sb_q [$];

    memory_helper_solver u_dut (
        .clk         (clk),
        .rst         (rst),
        .addr_req    (addr_req),
        .mem_mode    (mem_mode),
        .st_data_in  (st_data_in),
        .acc_valid   (acc_valid),
        .ld_bus_data (ld_bus_data),
        .addr        (addr),
        .msize       (msize),
        .strobe      (strobe),
        .st_data     (st_data),
        .ld_data     (ld_data),
        .misaligned  (misaligned),
        .err_sticky  (err_sticky),
        .err_addr    (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] a, input logic [2:0] mode,
                         input logic [63:0] st_in, input logic [63:0] bus, input logic av);
        addr_req    = a;
        mem_mode    = mode;
        st_data_in  = st_in;
        ld_bus_data = bus;
        acc_valid   = av;
    endtask

    task automatic apply(input int idx);
        vec_t e;
        drive(tbl[idx].a, tbl[idx].mode, tbl[idx].st_in, tbl[idx].bus, 1'b0);
        sb_q.push_back(tbl[idx]);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("v%0d addr", idx),    addr,                e.a);
        chk($sformatf("v%0d msize", idx),   {61'd0, msize},      {61'd0, e.msize});
        chk($sformatf("v%0d strobe", idx),  {56'd0, strobe},     {56'd0, e.strobe});
        chk($sformatf("v%0d st_data", idx), st_data,             e.st_data);
        chk($sformatf("v%0d ld_data", idx), ld_data,             e.ld);
        chk($sformatf("v%0d misalign", idx), {63'd0, misaligned}, {63'd0, e.mis});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            addr          mode    st_in                  bus                    msz  strobe  st_data                ld                     mis
        tbl[0]  = '{64'h1003, 3'b000, 64'hAB,                64'h0,                 3'd0, 8'h08, 64'h00000000AB000000, 64'h0,                 1'b0};
        tbl[1]  = '{64'h1004, 3'b010, 64'h12345678,          64'h0,                 3'd2, 8'hF0, 64'h1234567800000000, 64'h0,                 1'b0};
        tbl[2]  = '{64'h1007, 3'b000, 64'h0,                 64'h8000000000000000,  3'd0, 8'h80, 64'h0,                 64'hFFFFFFFFFFFFFF80,  1'b0};
        tbl[3]  = '{64'h1007, 3'b100, 64'h0,                 64'h8000000000000000,  3'd0, 8'h80, 64'h0,                 64'h80,                1'b0};
        tbl[4]  = '{64'h1002, 3'b001, 64'h0,                 64'h00000000BEEF0000,  3'd1, 8'h0C, 64'h0,                 64'hFFFFFFFFFFFFBEEF,  1'b0};
        tbl[5]  = '{64'h1002, 3'b101, 64'h0,                 64'h00000000BEEF0000,  3'd1, 8'h0C, 64'h0,                 64'hBEEF,              1'b0};
        tbl[6]  = '{64'h4,    3'b010, 64'h0,                 64'h8000000000000000,  3'd2, 8'hF0, 64'h0,                 64'hFFFFFFFF80000000,  1'b0};
        tbl[7]  = '{64'h4,    3'b110, 64'h0,                 64'h8000000000000000,  3'd2, 8'hF0, 64'h0,                 64'h80000000,          1'b0};
        tbl[8]  = '{64'h2000, 3'b011, 64'h0123456789ABCDEF,  64'hFEDCBA9876543210,  3'd3, 8'hFF, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210,  1'b0};
        tbl[9]  = '{64'h1005, 3'b111, 64'hFF,                64'hFFFFFFFFFFFFFFFF,  3'd0, 8'h00, 64'h0000FF0000000000, 64'h0,                 1'b0};
        tbl[10] = '{64'h0,    3'b000, 64'hFFFFFFFFFFFFFFFF,  64'h7F,                3'd0, 8'h01, 64'hFFFFFFFFFFFFFFFF, 64'h7F,                1'b0};
        tbl[11] = '{64'h1006, 3'b001, 64'hFFFFFFFFFFFFCAFE,  64'h1234000000000000,  3'd1, 8'hC0, 64'hCAFE000000000000, 64'h1234,              1'b0};
        tbl[12] = '{64'h1001, 3'b001, 64'hFF,                64'h0000000000ABCD00,  3'd1, c_chk ? 8'h00 : 8'h06, 64'hFF00, 64'hFFFFFFFFFFFFABCD, c_chk};
        tbl[13] = '{64'h2003, 3'b011, 64'h11,                64'h0,                 3'd3, c_chk ? 8'h00 : 8'hF8, 64'h11000000, 64'h0,             c_chk};
        tbl[14] = '{64'h1006, 3'b010, 64'h0,                 64'hAABB000000000000,  3'd2, c_chk ? 8'h00 : 8'hC0, 64'h0,    64'hAABB,            c_chk};

        // Combinational outputs stay live while reset is held
        rst = 1'b1;
        drive(64'h0, 3'b000, 64'h0, 64'h0, 1'b0);
        #1;
        chk("reset err_sticky", {63'd0, err_sticky}, 64'd0);
        chk("reset err_addr", err_addr, 64'd0);
        apply(0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            apply(i);
        end

        // Misaligned access without acc_valid must not be captured
        @(negedge clk);
        drive(64'h3001, 3'b001, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        chk("no_valid err_sticky", {63'd0, err_sticky}, 64'd0);
        // Aligned valid access must not be captured either
        drive(64'h3000, 3'b011, 64'h0, 64'h0, 1'b1);
        @(negedge clk);
        chk("aligned err_sticky", {63'd0, err_sticky}, 64'd0);

        drive(64'h1001, 3'b001, 64'h0, 64'h0, 1'b1);
        #1;
        chk("sh1001 misaligned", {63'd0, misaligned}, {63'd0, c_chk});
        chk("sh1001 strobe", {56'd0, strobe}, c_chk ? 64'h00 : 64'h06);
        @(negedge clk);
        chk("first err_sticky", {63'd0, err_sticky}, {63'd0, c_chk});
        chk("first err_addr", err_addr, c_chk ? 64'h1001 : 64'h0);

        drive(64'h2003, 3'b010, 64'h0, 64'h0, 1'b1);
        @(negedge clk);
        chk("second err_sticky", {63'd0, err_sticky}, {63'd0, c_chk});
        chk("second err_addr kept", err_addr, c_chk ? 64'h1001 : 64'h0);

        drive(64'h3000, 3'b011, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        chk("sticky holds", {63'd0, err_sticky}, {63'd0, c_chk});

        // Asynchronous clear away from any clock edge
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst err_sticky", {63'd0, err_sticky}, 64'd0);
        chk("async rst err_addr", err_addr, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst err_sticky", {63'd0, err_sticky}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_helper_solver.md
MEMORY_HELPER_SOLVER -- requirements
Module: memory_helper_solver

Interface
REQ-001 SHALL have port: clk  in  1  clock; rising edge active.
REQ-002 SHALL have port: rst  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have port: addr_req  in  64  byte address of access.
REQ-004 SHALL have port: mem_mode  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 reserved.
REQ-005 SHALL have port: st_data_in  in  64  store operand, value in low bytes.
REQ-006 SHALL have port: acc_valid  in  1  access presented this cycle; qualifies error capture only.
REQ-007 SHALL have port: ld_bus_data  in  64  raw 8-byte bus word returned for a load.
REQ-008 SHALL have port: addr  out  64  bus address.
REQ-009 SHALL have port: msize  out  3  size code: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-010 SHALL have port: strobe  out  8  byte-lane write enables.
REQ-011 SHALL have port: st_data  out  64  lane-aligned store data.
REQ-012 SHALL have port: ld_data  out  64  extracted, extended load result.
REQ-013 SHALL have port: misaligned  out  1  current access is misaligned.
REQ-014 SHALL have port: err_sticky  out  1  registered sticky misalignment flag.
REQ-015 SHALL have port: err_addr  out  64  registered address of first misaligned access.

Function
REQ-016 SHALL drive addr, msize, strobe, st_data, ld_data and misaligned combinationally from current inputs, zero latency.
REQ-017 SHALL set addr = addr_req unmodified.
REQ-018 SHALL set msize: 000/100 -> 0; 001/101 -> 1; 010/110 -> 2; 011 -> 3; 111 -> 0.
REQ-019 SHALL set off = addr_req[2:0]; strobe = base mask (0x01, 0x03, 0x0F, 0xFF by size) shifted left by off, truncated to 8 bits; mem_mode 111 -> strobe 0x00.
REQ-020 SHALL set st_data = st_data_in shifted left by 8*off, truncated to 64 bits.
REQ-021 SHALL compute ld_data: shift ld_bus_data right by 8*off, keep low 8/16/32/64 bits per size.
REQ-022 SHALL sign-extend for modes 000, 001 and 010; zero-extend for 100, 101 and 110; mode 011 passes 64 bits; mode 111 yields 0.
REQ-023 SHALL assert misaligned when a halfword has addr_req[0]!=0, a word has addr_req[1:0]!=0, or a doubleword has addr_req[2:0]!=0; byte accesses are never misaligned.

Reset
REQ-024 SHALL, while rst is high, force err_sticky=0 and err_addr=0 asynchronously.
REQ-025 SHALL keep all combinational outputs valid during reset, as pure functions of inputs.
REQ-026 SHALL, after reset deassertion, set err_sticky on the first clk edge with acc_valid and misaligned both 1; err_addr latches addr_req only when err_sticky was 0 (first error retained); err_sticky stays 1 until reset.

Configuration
REQ-027 SHALL provide macro MEM_MISALIGN_CHECK_EN.
REQ-028 SHALL, with MEM_MISALIGN_CHECK_EN defined, implement REQ-023 and REQ-026, and force strobe to 0x00 whenever misaligned=1.
REQ-029 SHALL, without MEM_MISALIGN_CHECK_EN, tie misaligned, err_sticky and err_addr to 0 and leave strobe unmasked; lanes shifted past lane 7 are dropped.

Verification
REQ-030 SHALL cover: SB, addr 0x1003, st_data_in 0xAB -> msize 0, strobe 0x08, st_data 0x00000000AB000000.
REQ-031 SHALL cover: SW, addr 0x1004, st_data_in 0x12345678 -> msize 2, strobe 0xF0, st_data 0x1234567800000000.
REQ-032 SHALL cover: addr 0x1007, bus 0x80000000_00000000 -> LB gives 0xFFFFFFFFFFFFFF80; LBU gives 0x80.
REQ-033 SHALL cover: addr 0x1002, bus 0x00000000_BEEF0000 -> LH gives 0xFFFFFFFFFFFFBEEF, LHU gives 0xBEEF; at addr 0x4 with bus 0x80000000_00000000, LW gives 0xFFFFFFFF80000000 and LWU gives 0x80000000.
REQ-034 SHALL cover (macro on): SH, addr 0x1001, acc_valid=1 -> misaligned 1, strobe 0x00; after one clk err_sticky 1 and err_addr 0x1001; a later misaligned access at 0x2003 leaves err_addr 0x1001; asserting rst mid-cycle clears both at once.
REQ-035 SHALL cover (macro off): same SH stimulus -> misaligned 0, strobe 0x06, err_sticky stays 0.
